// File: rtl/sme_feeder.sv
// Buffers host string/pattern records and replays them to the SME as one strobed burst, then republishes the result.
// First strobe 1 cycle after a pattern record's last byte; host_ready is low while sending or awaiting the SME.
module sme_feeder #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] host_data,
  input  logic       host_type,
  input  logic       host_last,
  input  logic       host_valid,
  output logic       host_ready,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       ovf,
  output logic       err_timeout
);

  localparam int BUF_MAX = (STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX;
  localparam int LW      = $clog2(BUF_MAX + 1);
  localparam int SIW     = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
  localparam int PIW     = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
  localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND_STR,
    SEND_PAT,
    WAIT_RES
  } state_t;

  state_t        state;
  logic [7:0]    str_buf [STR_MAX];
  logic [7:0]    pat_buf [PAT_MAX];
  logic [LW-1:0] len;
  logic [LW-1:0] str_len;
  logic [LW-1:0] pat_len;
  logic [LW-1:0] idx;
  logic [TW-1:0] wait_cnt;
  logic          rec_type;
  logic          str_pending;

  logic          xfer;
  logic          cur_type;
  logic [LW-1:0] wr_idx;
  logic [LW-1:0] cur_max;
  logic          room;
  logic [LW-1:0] new_len;

  // The record type is only sampled on the first byte; later bytes follow the latched type.
  assign xfer     = host_valid & host_ready;
  assign cur_type = (state == IDLE) ? host_type : rec_type;
  assign wr_idx   = (state == IDLE) ? '0 : len;
  assign cur_max  = cur_type ? LW'(PAT_MAX) : LW'(STR_MAX);
  assign room     = (wr_idx < cur_max);
  assign new_len  = room ? (wr_idx + LW'(1)) : wr_idx;

  // Record storage carries no reset: contents are only meaningful through the length registers.
  always_ff @(posedge clk) begin
    if (xfer && room) begin
      if (cur_type) begin
        pat_buf[wr_idx[PIW-1:0]] <= host_data;
      end else begin
        str_buf[wr_idx[SIW-1:0]] <= host_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      host_ready  <= 1'b0;
      chardata    <= 8'd0;
      isstring    <= 1'b0;
      ispattern   <= 1'b0;
      res_valid   <= 1'b0;
      res_match   <= 1'b0;
      res_index   <= 5'd0;
      ovf         <= 1'b0;
      err_timeout <= 1'b0;
      len         <= '0;
      str_len     <= '0;
      pat_len     <= '0;
      idx         <= '0;
      wait_cnt    <= '0;
      rec_type    <= 1'b0;
      str_pending <= 1'b0;
    end else begin
      res_valid   <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          host_ready <= 1'b1;
          if (xfer) begin
            if (state == IDLE) begin
              rec_type <= host_type;
              ovf      <= 1'b0;
            end else if (!room) begin
              ovf <= 1'b1;
            end
            if (host_last) begin
              if (!cur_type) begin
                str_len     <= new_len;
                str_pending <= 1'b1;
                state       <= IDLE;
              end else begin
                pat_len    <= new_len;
                idx        <= '0;
                host_ready <= 1'b0;
                state      <= str_pending ? SEND_STR : SEND_PAT;
              end
            end else begin
              len   <= new_len;
              state <= LOAD;
            end
          end
        end

        // String bytes run straight into pattern bytes: the SME would capture any gap byte.
        SEND_STR: begin
          chardata  <= str_buf[idx[SIW-1:0]];
          isstring  <= 1'b1;
          ispattern <= 1'b0;
          if (idx == str_len - LW'(1)) begin
            idx         <= '0;
            str_pending <= 1'b0;
            state       <= SEND_PAT;
          end else begin
            idx <= idx + LW'(1);
          end
        end

        SEND_PAT: begin
          chardata  <= pat_buf[idx[PIW-1:0]];
          isstring  <= 1'b0;
          ispattern <= 1'b1;
          if (idx == pat_len - LW'(1)) begin
            wait_cnt <= '0;
            state    <= WAIT_RES;
          end else begin
            idx <= idx + LW'(1);
          end
        end

        WAIT_RES: begin
          isstring  <= 1'b0;
          ispattern <= 1'b0;
          if (sme_valid) begin
            res_valid  <= 1'b1;
            res_match  <= sme_match;
            res_index  <= sme_index;
            host_ready <= 1'b1;
            state      <= IDLE;
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            host_ready  <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end

        default: begin
          host_ready <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
